collision_stats: RTL and testbench
==================================

# collision_stats

Per-frame collision statistics accumulator placed directly downstream of the collision counter. It consumes one collision count per pixel as the raster stream passes. Over a frame it tallies colliding pixels, the total excess overlap, the peak overlap and the index of the first colliding pixel. At frame end it presents the results on a valid/ready register interface for the host/debug logic, and accumulation of the next frame continues in parallel.

## Interface
- WIDTH, 2, number of components feeding the collision counter; maximum legal count
- CNT_W, 24, width of the pixel-tally accumulators
- PIX_W, 20, width of the pixel index
- clk  in  1  clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- frame_start  in  1  single-cycle pulse: begin a new frame
- pixel_valid  in  1  collision_num carries a valid pixel this cycle
- collision_num  in  32  signed integer count of components active on this pixel
- frame_end  in  1  single-cycle pulse: frame complete; a pixel_valid pixel in the same cycle belongs to the ending frame
- stats_ready  in  1  consumer accepts stats this cycle
- stats_valid  out  1  stats outputs hold a completed frame
- collided_pixels  out  CNT_W  pixels with count >= 2
- overlap_sum  out  CNT_W  sum of (count - 1) over colliding pixels
- max_collision  out  32  largest count seen in the frame; 0 if no pixels
- first_idx  out  PIX_W  index of the first colliding pixel; valid only when first_found = 1
- first_found  out  1  at least one colliding pixel in the frame
- busy  out  1  FSM in ACCUM
- overrun  out  1  sticky: a finished frame was dropped

## Operation
- FSM states are IDLE and ACCUM. Reset forces IDLE.
- IDLE:
  - frame_start → ACCUM; accumulators cleared; pixel index set to 0.
  - pixel_valid and frame_end are ignored.
- ACCUM:
  - Each pixel_valid cycle: count c = clamp(collision_num, 0, WIDTH), where negative → 0 and above WIDTH → WIDTH.
  - If c >= 2: collided_pixels acc += 1 and overlap acc += c - 1. If no collision has been seen yet, first_idx acc ← pixel index and first flag ← 1.
  - max acc ← max(max acc, c).
  - Pixel index += 1 after each valid pixel.
- Arithmetic:
  - Accumulators and pixel index saturate at all-ones and never wrap.
  - A pixel past index saturation records first_idx as all-ones.
- frame_end in ACCUM:
  - Accumulated values, including that cycle's pixel, transfer to the output registers.
  - stats_valid is set.
  - FSM → IDLE.
- frame_end together with frame_start in ACCUM: end processed first, then accumulators cleared and FSM stays in ACCUM.
- frame_start in ACCUM without frame_end: partial frame discarded silently; accumulators cleared; FSM stays in ACCUM.
- Output handshake:
  - Outputs are stable while stats_valid = 1 and stats_ready = 0.
  - stats_valid && stats_ready → stats_valid clears next cycle; stat values are retained.
- Frame end with stats_valid = 1 and stats_ready = 0: new results dropped, old results held, overrun ← 1.
- Frame end with stats_valid = 1 and stats_ready = 1 in the same cycle: new results loaded, stats_valid stays 1, no overrun.
- overrun clears only on reset.
- Reset mid-frame or mid-handshake: everything cleared, nothing reported.

## Timing
- Reset values:
  - stats_valid = 0, busy = 0, overrun = 0, first_found = 0.
  - collided_pixels, overlap_sum, max_collision and first_idx = 0.
  - FSM = IDLE, pixel index = 0.
- Throughput: one pixel per clock, no stalls; there is no backpressure on the pixel stream.
- Latency: frame_end sampled at edge N → stats_valid and new values visible after edge N.
- busy is 1 in the cycle after a frame_start edge and 0 in the cycle after a frame_end edge, unless frame_start coincides.
- stats_ready is only meaningful while stats_valid = 1.

## Test plan
- Reset, then a 4-pixel frame (WIDTH=4) with counts 0,2,3,1, frame_end coinciding with the last pixel:
  - collided_pixels=2, overlap_sum=3, max_collision=3, first_idx=1, first_found=1.
  - stats_valid=1 one cycle after frame_end.
- Frame of counts 0,1,0 → collided_pixels=0, overlap_sum=0, max_collision=1, first_found=0.
- Counts 7 and -5 with WIDTH=4 → clamped to 4 and 0: collided_pixels=1, overlap_sum=3, max_collision=4.
- Two back-to-back frames with stats_ready held 0: second frame dropped, overrun=1, first frame's values unchanged.
  - Repeat with stats_ready=1 on the second frame_end cycle: second frame's values loaded and overrun stays 0.
- frame_start mid-frame after 3 colliding pixels, then 1 colliding pixel, then frame_end → collided_pixels=1, first_idx=0.
- CNT_W=3: 9 pixels with count 2 → collided_pixels=7 and overlap_sum=7 (saturated). Then assert reset mid-frame → all outputs 0 on the next cycle.

Source files
------------

// File: rtl/collision_stats.sv
// Per-frame collision statistics: tallies colliding pixels, excess overlap, peak count and
// first colliding pixel index, then hands the results to the host over a valid/ready register.
module collision_stats #(
    parameter int WIDTH = 2,
    parameter int CNT_W = 24,
    parameter int PIX_W = 20
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                frame_start,
    input  logic                pixel_valid,
    input  logic signed [31:0]  collision_num,
    input  logic                frame_end,
    input  logic                stats_ready,
    output logic                stats_valid,
    output logic [CNT_W-1:0]    collided_pixels,
    output logic [CNT_W-1:0]    overlap_sum,
    output logic [31:0]         max_collision,
    output logic [PIX_W-1:0]    first_idx,
    output logic                first_found,
    output logic                busy,
    output logic                overrun
);

    localparam int SW = ((CNT_W > 32) ? CNT_W : 32) + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [PIX_W-1:0] PIX_MAX = '1;

    typedef enum logic {S_IDLE, S_ACCUM} state_t;

    state_t             r_state, w_next_state;

    logic [CNT_W-1:0]   r_acc_cnt, r_acc_ovl;
    logic [31:0]        r_acc_max;
    logic [PIX_W-1:0]   r_acc_fidx, r_pix_idx;
    logic               r_acc_ff;

    logic [CNT_W-1:0]   r_out_cnt, r_out_ovl;
    logic [31:0]        r_out_max;
    logic [PIX_W-1:0]   r_out_fidx;
    logic               r_out_ff, r_stats_valid, r_overrun;

    logic [31:0]        w_c;
    logic [SW-1:0]      w_ovl_ext;
    logic [CNT_W-1:0]   w_new_cnt, w_new_ovl;
    logic [31:0]        w_new_max;
    logic [PIX_W-1:0]   w_new_fidx, w_new_pix;
    logic               w_new_ff, w_end;

    always_comb begin
        w_c = collision_num[31:0];
        if (collision_num < 0)
            w_c = '0;
        else if (collision_num > $signed(32'(WIDTH)))
            w_c = 32'(WIDTH);
    end

    assign w_ovl_ext = SW'(r_acc_ovl) + SW'(w_c - 32'd1);
    assign w_end     = (r_state == S_ACCUM) && frame_end;

    // Next accumulator values including this cycle's pixel; feeds both the
    // accumulators and the output registers so a frame_end pixel is counted.
    always_comb begin
        w_new_cnt  = r_acc_cnt;
        w_new_ovl  = r_acc_ovl;
        w_new_max  = r_acc_max;
        w_new_fidx = r_acc_fidx;
        w_new_ff   = r_acc_ff;
        w_new_pix  = r_pix_idx;
        if ((r_state == S_ACCUM) && pixel_valid) begin
            if (w_c > r_acc_max)
                w_new_max = w_c;
            if (w_c >= 32'd2) begin
                w_new_cnt = (r_acc_cnt == CNT_MAX) ? CNT_MAX : r_acc_cnt + CNT_W'(1);
                w_new_ovl = (w_ovl_ext > SW'(CNT_MAX)) ? CNT_MAX : w_ovl_ext[CNT_W-1:0];
                if (!r_acc_ff) begin
                    w_new_fidx = r_pix_idx;
                    w_new_ff   = 1'b1;
                end
            end
            w_new_pix = (r_pix_idx == PIX_MAX) ? PIX_MAX : r_pix_idx + PIX_W'(1);
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (frame_start) w_next_state = S_ACCUM;
            S_ACCUM: if (frame_end && !frame_start) w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset)
            r_state <= S_IDLE;
        else
            r_state <= w_next_state;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_acc_cnt     <= '0;
            r_acc_ovl     <= '0;
            r_acc_max     <= '0;
            r_acc_fidx    <= '0;
            r_acc_ff      <= 1'b0;
            r_pix_idx     <= '0;
            r_out_cnt     <= '0;
            r_out_ovl     <= '0;
            r_out_max     <= '0;
            r_out_fidx    <= '0;
            r_out_ff      <= 1'b0;
            r_stats_valid <= 1'b0;
            r_overrun     <= 1'b0;
        end else begin
            if (frame_start) begin
                r_acc_cnt  <= '0;
                r_acc_ovl  <= '0;
                r_acc_max  <= '0;
                r_acc_fidx <= '0;
                r_acc_ff   <= 1'b0;
                r_pix_idx  <= '0;
            end else begin
                r_acc_cnt  <= w_new_cnt;
                r_acc_ovl  <= w_new_ovl;
                r_acc_max  <= w_new_max;
                r_acc_fidx <= w_new_fidx;
                r_acc_ff   <= w_new_ff;
                r_pix_idx  <= w_new_pix;
            end

            if (w_end) begin
                if (!r_stats_valid || stats_ready) begin
                    r_out_cnt     <= w_new_cnt;
                    r_out_ovl     <= w_new_ovl;
                    r_out_max     <= w_new_max;
                    r_out_fidx    <= w_new_fidx;
                    r_out_ff      <= w_new_ff;
                    r_stats_valid <= 1'b1;
                end else begin
                    r_overrun     <= 1'b1;
                end
            end else if (r_stats_valid && stats_ready) begin
                r_stats_valid <= 1'b0;
            end
        end
    end

    assign stats_valid     = r_stats_valid;
    assign collided_pixels = r_out_cnt;
    assign overlap_sum     = r_out_ovl;
    assign max_collision   = r_out_max;
    assign first_idx       = r_out_fidx;
    assign first_found     = r_out_ff;
    assign busy            = (r_state == S_ACCUM);
    assign overrun         = r_overrun;

endmodule

// File: tb/tb_collision_stats.sv
// Directed bench for collision_stats with WIDTH=4, CNT_W=3, PIX_W=3 so clamping,
// counter saturation and pixel-index saturation are all reachable in short frames.
module tb_collision_stats;

    localparam int WIDTH = 4;
    localparam int CNT_W = 3;
    localparam int PIX_W = 3;

    logic               clk = 1'b0;
    logic               reset, frame_start, pixel_valid, frame_end, stats_ready;
    logic signed [31:0] collision_num;
    logic               stats_valid, first_found, busy, overrun;
    logic [CNT_W-1:0]   collided_pixels, overlap_sum;
    logic [31:0]        max_collision;
    logic [PIX_W-1:0]   first_idx;

    int n_tests = 0;
    int n_fail  = 0;

    collision_stats #(.WIDTH(WIDTH), .CNT_W(CNT_W), .PIX_W(PIX_W)) dut (
        .clk(clk), .reset(reset), .frame_start(frame_start), .pixel_valid(pixel_valid),
        .collision_num(collision_num), .frame_end(frame_end), .stats_ready(stats_ready),
        .stats_valid(stats_valid), .collided_pixels(collided_pixels), .overlap_sum(overlap_sum),
        .max_collision(max_collision), .first_idx(first_idx), .first_found(first_found),
        .busy(busy), .overrun(overrun)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_stats(input string tag, input logic v, input int cp, input int ov,
                             input int mx, input int fi, input logic ff);
        chk({tag, ".valid"}, 32'(stats_valid), 32'(v));
        chk({tag, ".collided"}, 32'(collided_pixels), 32'(cp));
        chk({tag, ".overlap"}, 32'(overlap_sum), 32'(ov));
        chk({tag, ".max"}, max_collision, 32'(mx));
        if (ff) chk({tag, ".first_idx"}, 32'(first_idx), 32'(fi));
        chk({tag, ".first_found"}, 32'(first_found), 32'(ff));
    endtask

    // One pixel cycle with optional frame_end / frame_start alongside.
    task automatic pix(input int c, input logic fe, input logic fs);
        pixel_valid   = 1'b1;
        collision_num = c;
        frame_end     = fe;
        frame_start   = fs;
        step();
        pixel_valid   = 1'b0;
        frame_end     = 1'b0;
        frame_start   = 1'b0;
        collision_num = 0;
    endtask

    task automatic start();
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
    endtask

    task automatic consume();
        stats_ready = 1'b1;
        step();
        stats_ready = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; frame_start = 1'b0; pixel_valid = 1'b0; frame_end = 1'b0;
        stats_ready = 1'b0; collision_num = 0;
        step(); step();
        reset = 1'b0;

        chk("rst.busy", 32'(busy), 0);
        chk("rst.overrun", 32'(overrun), 0);
        chk("rst.first_idx", 32'(first_idx), 0);
        chk_stats("rst", 0, 0, 0, 0, 0, 0);

        // IDLE ignores pixels and frame_end
        pix(4, 1'b1, 1'b0);
        chk("idle.valid", 32'(stats_valid), 0);
        chk("idle.busy", 32'(busy), 0);

        // counts 0,2,3,1 with frame_end on the last pixel
        start();
        chk("f1.busy_on", 32'(busy), 1);
        pix(0, 1'b0, 1'b0);
        pix(2, 1'b0, 1'b0);
        pix(3, 1'b0, 1'b0);
        chk("f1.valid_pre", 32'(stats_valid), 0);
        pix(1, 1'b1, 1'b0);
        chk_stats("f1", 1, 2, 3, 3, 1, 1);
        chk("f1.busy_off", 32'(busy), 0);
        consume();
        chk("f1.valid_clr", 32'(stats_valid), 0);
        chk("f1.retain", 32'(collided_pixels), 2);

        // no collisions
        start();
        pix(0, 1'b0, 1'b0);
        pix(1, 1'b0, 1'b0);
        pix(0, 1'b1, 1'b0);
        chk_stats("f2", 1, 0, 0, 1, 0, 0);
        consume();

        // clamping
        start();
        pix(7, 1'b0, 1'b0);
        pix(-5, 1'b1, 1'b0);
        chk_stats("clamp", 1, 1, 3, 4, 0, 1);
        consume();

        // overrun: second frame dropped while first unconsumed
        start();
        pix(2, 1'b1, 1'b0);
        chk_stats("ovr.a", 1, 1, 1, 2, 0, 1);
        start();
        pix(0, 1'b0, 1'b0);
        pix(3, 1'b0, 1'b0);
        pix(4, 1'b1, 1'b0);
        chk("ovr.flag", 32'(overrun), 1);
        chk_stats("ovr.held", 1, 1, 1, 2, 0, 1);
        consume();
        chk("ovr.sticky", 32'(overrun), 1);

        // same, but stats_ready on the second frame_end, with frame_start coinciding
        do_reset();
        chk("rst2.overrun", 32'(overrun), 0);
        start();
        pix(2, 1'b1, 1'b0);
        start();
        pix(0, 1'b0, 1'b0);
        stats_ready = 1'b1;
        pix(3, 1'b1, 1'b1);
        stats_ready = 1'b0;
        chk("rdy.overrun", 32'(overrun), 0);
        chk_stats("rdy", 1, 1, 2, 3, 1, 1);
        chk("rdy.busy_stay", 32'(busy), 1);
        consume();
        chk("rdy.valid_clr", 32'(stats_valid), 0);
        pix(2, 1'b1, 1'b0);
        chk_stats("rdy.next", 1, 1, 1, 2, 0, 1);
        chk("rdy.busy_off", 32'(busy), 0);
        consume();

        // restart mid-frame discards partial frame
        start();
        pix(2, 1'b0, 1'b0);
        pix(2, 1'b0, 1'b0);
        pix(2, 1'b0, 1'b0);
        start();
        chk("restart.valid", 32'(stats_valid), 0);
        pix(3, 1'b1, 1'b0);
        chk_stats("restart", 1, 1, 2, 3, 0, 1);
        consume();

        // CNT_W=3 saturation: 9 pixels of count 2
        start();
        for (int i = 0; i < 8; i++) pix(2, 1'b0, 1'b0);
        pix(2, 1'b1, 1'b0);
        chk_stats("sat", 1, 7, 7, 2, 0, 1);
        consume();

        // PIX_W=3: first collision after index saturation records all-ones
        start();
        for (int i = 0; i < 9; i++) pix(0, 1'b0, 1'b0);
        pix(2, 1'b1, 1'b0);
        chk_stats("idxsat", 1, 1, 1, 2, 7, 1);

        // reset mid-frame with results still pending
        start();
        pix(2, 1'b0, 1'b0);
        pix(2, 1'b0, 1'b0);
        do_reset();
        chk("rstmid.busy", 32'(busy), 0);
        chk("rstmid.overrun", 32'(overrun), 0);
        chk("rstmid.first_idx", 32'(first_idx), 0);
        chk_stats("rstmid", 0, 0, 0, 0, 0, 0);
        pix(2, 1'b1, 1'b0);
        chk("rstmid.idle", 32'(stats_valid), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
